// File: rtl/mem_access_unit.sv
// MAR/MDR front end running single SRAM read/write transactions
// with a fixed wait-state count and a one-cycle ready pulse.
module mem_access_unit #(
    parameter int N    = 16,
    parameter int WAIT = 2
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] BUS,
    input  logic         LD_MAR,
    input  logic         INC_MAR,
    input  logic         LD_MDR,
    input  logic         START,
    input  logic         RW,
    input  logic [N-1:0] MEM_RDATA,
    output logic [N-1:0] MAR_OUT,
    output logic [N-1:0] MDR_OUT,
    output logic [N-1:0] MEM_WDATA,
    output logic         MEM_CE_n,
    output logic         MEM_OE_n,
    output logic         MEM_WE_n,
    output logic         BUSY,
    output logic         R
);

    localparam int CW = $clog2(WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mar_q, mar_d;
    logic [N-1:0]   mdr_q, mdr_d;
    logic           rw_q, rw_d;
    logic           access;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rw_q    <= rw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rw_d    = rw_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (LD_MAR) begin
                    mar_d = BUS;
                end else if (INC_MAR) begin
                    mar_d = mar_q + N'(1);
                end
                if (LD_MDR) begin
                    mdr_d = BUS;
                end
                // Loads above land on the same edge, so the access
                // starts with the freshly loaded MAR/MDR.
                if (START) begin
                    rw_d    = RW;
                    cnt_d   = CW'(WAIT - 1);
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_DONE;
                    if (rw_q) begin
                        mdr_d = MEM_RDATA;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign access    = (state_q == S_ACCESS);
    assign MAR_OUT   = mar_q;
    assign MDR_OUT   = mdr_q;
    assign MEM_WDATA = mdr_q;
    assign MEM_CE_n  = !access;
    assign MEM_OE_n  = !(access && rw_q);
    assign MEM_WE_n  = !(access && !rw_q);
    assign BUSY      = access;
    assign R         = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, corner sequences and
// random traffic against a cycle-age transaction model.
module tb_mem_access_unit;

    localparam int N    = 16;
    localparam int WAIT = 2;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic [N-1:0] BUS = '0;
    logic         LD_MAR = 1'b0;
    logic         INC_MAR = 1'b0;
    logic         LD_MDR = 1'b0;
    logic         START = 1'b0;
    logic         RW = 1'b0;
    logic [N-1:0] MEM_RDATA = '0;
    logic [N-1:0] MAR_OUT, MDR_OUT, MEM_WDATA;
    logic         MEM_CE_n, MEM_OE_n, MEM_WE_n, BUSY, R;

    mem_access_unit #(.N(N), .WAIT(WAIT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .BUS(BUS),
        .LD_MAR(LD_MAR), .INC_MAR(INC_MAR), .LD_MDR(LD_MDR),
        .START(START), .RW(RW), .MEM_RDATA(MEM_RDATA),
        .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT), .MEM_WDATA(MEM_WDATA),
        .MEM_CE_n(MEM_CE_n), .MEM_OE_n(MEM_OE_n), .MEM_WE_n(MEM_WE_n),
        .BUSY(BUSY), .R(R)
    );

    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        ld_mar, inc, ld_mdr, start, rw;
        logic [15:0] bus, rdata;
        logic [15:0] e_mar, e_mdr;
        logic        e_ce, e_oe, e_we, e_busy, e_r;
    } vec_t;

    vec_t vq[$];

    // Model: age = cycles since the START edge (-1 when no access).
    int          m_age;
    logic [15:0] m_mar, m_mdr;
    logic        m_rw;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] mar,
                           input logic [15:0] mdr, input logic ce,
                           input logic oe, input logic we,
                           input logic busy, input logic r);
        chk({tag, ".mar"}, 32'(MAR_OUT), 32'(mar));
        chk({tag, ".mdr"}, 32'(MDR_OUT), 32'(mdr));
        chk({tag, ".wdata"}, 32'(MEM_WDATA), 32'(mdr));
        chk({tag, ".ce_n"}, 32'(MEM_CE_n), 32'(ce));
        chk({tag, ".oe_n"}, 32'(MEM_OE_n), 32'(oe));
        chk({tag, ".we_n"}, 32'(MEM_WE_n), 32'(we));
        chk({tag, ".busy"}, 32'(BUSY), 32'(busy));
        chk({tag, ".r"}, 32'(R), 32'(r));
    endtask

    task automatic model_reset();
        m_age = -1;
        m_mar = '0;
        m_mdr = '0;
        m_rw  = 1'b0;
    endtask

    task automatic model_edge();
        if (m_age < 0 || m_age == WAIT + 1) begin
            if (LD_MAR) m_mar = BUS;
            else if (INC_MAR) m_mar = 16'((32'(m_mar) + 1) % 65536);
            if (LD_MDR) m_mdr = BUS;
            if (START) begin
                m_rw  = RW;
                m_age = 1;
            end else begin
                m_age = -1;
            end
        end else begin
            if (m_age == WAIT && m_rw) m_mdr = MEM_RDATA;
            m_age++;
        end
    endtask

    task automatic chk_model(input string tag);
        logic act;
        act = (m_age >= 1 && m_age <= WAIT);
        chk_all(tag, m_mar, m_mdr, !act, !(act && m_rw),
                !(act && !m_rw), act, m_age == WAIT + 1);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge Clk);
        #1;
        chk_model(tag);
    endtask

    task automatic idle_in();
        LD_MAR = 0; INC_MAR = 0; LD_MDR = 0; START = 0; RW = 0;
    endtask

    task automatic add(input logic lm, input logic inc, input logic ld,
                       input logic st, input logic rw,
                       input logic [15:0] bus, input logic [15:0] rd,
                       input logic [15:0] em, input logic [15:0] ed,
                       input logic ce, input logic oe, input logic we,
                       input logic bz, input logic r);
        vec_t v;
        v.ld_mar = lm; v.inc = inc; v.ld_mdr = ld; v.start = st;
        v.rw = rw; v.bus = bus; v.rdata = rd; v.e_mar = em; v.e_mdr = ed;
        v.e_ce = ce; v.e_oe = oe; v.e_we = we; v.e_busy = bz; v.e_r = r;
        vq.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        // lm inc ld st rw  bus      rdata    mar      mdr      ce oe we bz r
        add(1, 0, 0, 0, 0, 16'h3000, 16'h0000, 16'h3000, 16'h0000, 1, 1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h3000, 16'h0000, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h1111, 16'h3000, 16'h0000, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hBEEF, 16'h3000, 16'hBEEF, 1, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h3000, 16'hBEEF, 1, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 16'h1234, 16'h0000, 16'h3000, 16'h1234, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hDEAD, 16'h3000, 16'h1234, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hDEAD, 16'h3000, 16'h1234, 1, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h3000, 16'h1234, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h1234, 1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1, 1, 1, 0, 0);
        add(1, 1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0040, 16'h1234, 1, 1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0040, 16'h1234, 0, 0, 1, 1, 0);
        add(1, 1, 1, 1, 0, 16'hAAAA, 16'h5555, 16'h0040, 16'h1234, 0, 0, 1, 1, 0);
        add(1, 1, 1, 1, 0, 16'hAAAA, 16'hCAFE, 16'h0040, 16'hCAFE, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 16'h7777, 16'h0000, 16'h0040, 16'hCAFE, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0040, 16'hCAFE, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0040, 16'hCAFE, 1, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0040, 16'hCAFE, 1, 1, 1, 0, 0);

        model_reset();
        #12;
        chk_all("por", 16'h0, 16'h0, 1, 1, 1, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        foreach (vq[i]) begin
            LD_MAR = vq[i].ld_mar; INC_MAR = vq[i].inc;
            LD_MDR = vq[i].ld_mdr; START = vq[i].start; RW = vq[i].rw;
            BUS = vq[i].bus; MEM_RDATA = vq[i].rdata;
            model_edge();
            @(posedge Clk);
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].e_mar, vq[i].e_mdr,
                    vq[i].e_ce, vq[i].e_oe, vq[i].e_we, vq[i].e_busy,
                    vq[i].e_r);
        end
        idle_in();

        // Asynchronous reset mid-cycle clears state before the next edge.
        #2 Reset_n = 1'b0;
        #1 chk_all("rst_mid", 16'h0, 16'h0, 1, 1, 1, 0, 0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;

        // Abort a read in its second access cycle.
        LD_MAR = 1; BUS = 16'h2222;
        step("ab_ld");
        LD_MAR = 0; START = 1; RW = 1; MEM_RDATA = 16'h9999;
        step("ab_a1");
        START = 0;
        step("ab_a2");
        #2 Reset_n = 1'b0;
        #1 chk_all("ab_rst", 16'h0, 16'h0, 1, 1, 1, 0, 0);
        model_reset();
        @(posedge Clk);
        #1 chk("ab_no_r", 32'(R), 32'(0));
        chk("ab_mdr_hold", 32'(MDR_OUT), 32'(0));
        #3 Reset_n = 1'b1;
        START = 1; RW = 1;
        step("rr_a1");
        START = 0;
        step("rr_a2");
        MEM_RDATA = 16'h4B1D;
        step("rr_done");
        chk("rr_mdr", 32'(MDR_OUT), 32'h4B1D);
        chk("rr_r", 32'(R), 32'(1));
        step("rr_idle");

        for (int c = 0; c < 400; c++) begin
            LD_MAR  = ($urandom_range(0, 3) == 0);
            INC_MAR = ($urandom_range(0, 2) == 0);
            LD_MDR  = ($urandom_range(0, 3) == 0);
            START   = ($urandom_range(0, 2) == 0);
            RW      = 1'($urandom_range(0, 1));
            rd      = 16'($urandom);
            BUS     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : rd;
            MEM_RDATA = 16'($urandom);
            step($sformatf("rnd%0d", c));
        end
        idle_in();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-address/memory-data front end for the datapath. Holds the MAR and MDR and runs single read/write transactions to synchronous SRAM with a configurable wait-state count. Adds MAR post-increment and a ready handshake, so the FSM controller can start an access and poll `R` instead of hard-coding memory delay states. Sits between the datapath bus and the memory/IO port.

## Interface
Parameters:
- `N`, 16, width of address, data, MAR and MDR.
- `WAIT`, 2, number of cycles the memory strobes are held per access; legal range 1..15.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `BUS`  in  N  datapath bus value.
- `LD_MAR`  in  1  load MAR from `BUS`.
- `INC_MAR`  in  1  MAR <= MAR + 1, modulo 2^N.
- `LD_MDR`  in  1  load MDR from `BUS`.
- `START`  in  1  begin a memory access; single-cycle strobe.
- `RW`  in  1  access type, 1 = read, 0 = write; sampled with `START`.
- `MEM_RDATA`  in  N  read data from memory.
- `MAR_OUT`  out  N  MAR contents; drives the memory address.
- `MDR_OUT`  out  N  MDR contents, to the bus gate.
- `MEM_WDATA`  out  N  write data; equals MDR.
- `MEM_CE_n`, `MEM_OE_n`, `MEM_WE_n`  out  1 each  active-low memory strobes.
- `BUSY`  out  1  access in progress.
- `R`  out  1  one-cycle ready pulse at access completion.

## Operation
- FSM has three states:
  - IDLE
  - ACCESS, with a wait counter `cnt` of width clog2(WAIT+1)
  - DONE
- Reset (`Reset_n` = 0, asynchronous):
  - MAR = 0, MDR = 0, state = IDLE, `cnt` = 0.
  - All strobes = 1; `BUSY` = 0; `R` = 0.
- IDLE and DONE both accept register updates on the clock edge:
  - `LD_MAR` has priority over `INC_MAR`.
  - `INC_MAR` wraps: 2^N-1 -> 0.
  - `LD_MDR` loads MDR from `BUS`.
- In IDLE or DONE with `START` = 1:
  - Latch `RW`, go to ACCESS, set `cnt` = WAIT-1.
  - A load in the same cycle takes effect at the same edge, so the access uses the newly loaded MAR/MDR.
- Without `START`: DONE -> IDLE; IDLE stays IDLE.
- ACCESS:
  - `MEM_CE_n` = 0.
  - Read: `MEM_OE_n` = 0, `MEM_WE_n` = 1.
  - Write: `MEM_WE_n` = 0, `MEM_OE_n` = 1.
  - `BUSY` = 1.
  - `LD_MAR`, `INC_MAR`, `LD_MDR` and `START` are ignored, so address and write data stay stable.
- ACCESS with `cnt` ≠ 0: decrement `cnt`.
- ACCESS with `cnt` = 0: go to DONE. On a read, MDR <= `MEM_RDATA` at that same edge.
- DONE: `R` = 1 for exactly one cycle; strobes = 1; `BUSY` = 0.
- All outputs are registered-state decodes (Moore); no combinational path from inputs to outputs.

## Timing
- `START` sampled at edge E0:
  - Strobes are low for cycles E0..E0+WAIT.
  - `R` is high for the cycle after edge E0+WAIT.
  - Latency from `START` to `R` = WAIT+1 cycles.
- Read data is sampled on the final ACCESS edge. Memory must present valid data within WAIT cycles of address/strobe assertion.
- Back-to-back: `START` asserted during DONE begins the next access with no IDLE cycle. Throughput is one access per WAIT+1 cycles.
- Reset mid-access: strobes deassert immediately (asynchronous, not at the next edge). MDR is not updated. `R` is never pulsed for the aborted access.
- `MAR_OUT` changes only on edges in IDLE or DONE, never while strobes are asserted.

## Test plan
All scenarios use N = 16, WAIT = 2.
- **Reset:** hold `Reset_n` = 0 mid-cycle -> `MAR_OUT` = 0, `MDR_OUT` = 0, `MEM_CE_n`/`MEM_OE_n`/`MEM_WE_n` = 1, `BUSY` = 0, `R` = 0 before the next edge.
- **Read:** `BUS` = 0x3000 with `LD_MAR`; then `START`, `RW` = 1, memory returning 0xBEEF -> `MEM_CE_n` = `MEM_OE_n` = 0 for 2 cycles, `R` pulses 3 cycles after `START`, `MDR_OUT` = 0xBEEF.
- **Write with same-edge load:** `LD_MDR` with `BUS` = 0x1234, same cycle as `START` with `RW` = 0 -> `MEM_WE_n` = 0 for 2 cycles, `MEM_WDATA` = 0x1234 throughout, MDR unchanged after completion.
- **Increment wrap and priority:** MAR = 0xFFFF, `INC_MAR` -> `MAR_OUT` = 0x0000. Then `LD_MAR` (`BUS` = 0x0040) together with `INC_MAR` -> 0x0040.
- **Busy-ignore:** assert `LD_MAR`, `LD_MDR`, `START` and `INC_MAR` during ACCESS -> MAR/MDR unchanged, exactly one `R` pulse. Then `START` during DONE -> second access begins with no IDLE gap.
- **Abort:** drop `Reset_n` in the second ACCESS cycle of a read -> strobes high immediately, `MDR_OUT` = 0, no `R` pulse. After release, a new read completes normally.
